// File: rtl/udpoti_pkg.sv
// Shared types and helpers for the up/down pot setpoint conditioner.
package udpoti_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] target;
    logic         clamped;
  } clamp_t;

  // Clamp a signed host setpoint into 0..hi. hi is a non-negative bound, so once
  // sp is known to be non-negative an unsigned compare is exact.
  function automatic clamp_t clamp_sp(input logic signed [W-1:0] sp,
                                      input logic [W-1:0] hi);
    clamp_t r;
    if (sp < 0) begin
      r.target  = '0;
      r.clamped = 1'b1;
    end else if (W'(sp) > hi) begin
      r.target  = hi;
      r.clamped = 1'b1;
    end else begin
      r.target  = W'(sp);
      r.clamped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/udpoti_tick_div.sv
// Reloadable down-counter emitting a one-cycle tick every DIV clk cycles.
module udpoti_tick_div
  import udpoti_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  // Count down each cycle; wrap to the reload value on the tick cycle.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (tick_o) cnt_d = RELOAD;
  end

  // Counter register with synchronous reset to the reload value.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/udpoti_setpoint.sv
// Setpoint conditioner: latch+clamp host setpoint, slew output one step per
// tick toward the effective target, optional host-update watchdog.
// Optional feature macro: UDPOTI_SETPOINT_WATCHDOG_EN (watchdog / FAULT state).
module udpoti_setpoint
  import udpoti_pkg::*;
#(
  parameter int unsigned RESOLUTION = 100,
  parameter int unsigned SLEW_DIV   = 200000,
  parameter int unsigned TIMEOUT    = 50000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  setpoint,
  input  logic         setpoint_valid,
  input  logic         enable,
  output logic [31:0]  value,
  output logic         clamped,
  output logic         settled,
  output logic         fault
);

  localparam logic [W-1:0] RES       = W'(RESOLUTION);
  localparam logic [W-1:0] WD_RELOAD = W'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] value_q, value_d;
  logic         clamped_q, clamped_d;
  logic         settled_q, settled_d;
  logic         fault_q, fault_d;
  logic [W-1:0] eff_q, eff_d;
  logic         tick;
  clamp_t       clamp_res;

  udpoti_tick_div #(.DIV(SLEW_DIV)) u_slew_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign clamp_res = clamp_sp(setpoint, RES);

`ifdef UDPOTI_SETPOINT_WATCHDOG_EN
  logic [W-1:0] wd_q, wd_d;
  logic         wd_expired;
  // A strobe in the expiring cycle reloads instead of faulting.
  assign wd_expired = (wd_q == '0) && !setpoint_valid;
`else
  logic wd_expired;
  logic unused_timeout;
  assign wd_expired     = 1'b0;
  assign unused_timeout = ^WD_RELOAD;
`endif

  // Next-state: latch/clamp, mode FSM, slew step, settled and fault flags.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    clamped_d = clamped_q;
    value_d   = value_q;

    if (setpoint_valid) begin
      target_d  = clamp_res.target;
      clamped_d = clamp_res.clamped;
    end

    unique case (state_q)
      IDLE:    if (enable && !fault_q) state_d = TRACK;
      TRACK:   if (!enable)            state_d = IDLE;
               else if (wd_expired)    state_d = FAULT;
      FAULT:   if (!enable)            state_d = IDLE;
      default:                         state_d = IDLE;
    endcase

    eff_q = (state_q == TRACK) ? target_q : '0;
    if (tick) begin
      if (value_q < eff_q)      value_d = value_q + 1'b1;
      else if (value_q > eff_q) value_d = value_q - 1'b1;
    end

    eff_d     = (state_d == TRACK) ? target_d : '0;
    settled_d = (value_d == eff_d);
    fault_d   = (state_d == FAULT);
  end

  // Main state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      value_q   <= '0;
      clamped_q <= 1'b0;
      settled_q <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      value_q   <= value_d;
      clamped_q <= clamped_d;
      settled_q <= settled_d;
      fault_q   <= fault_d;
    end
  end

`ifdef UDPOTI_SETPOINT_WATCHDOG_EN
  // Watchdog next value: reload on strobe or TRACK entry, else count down in TRACK.
  always_comb begin
    wd_d = wd_q;
    if (setpoint_valid || (state_q != TRACK && state_d == TRACK))
      wd_d = WD_RELOAD;
    else if (state_q == TRACK && wd_q != '0)
      wd_d = wd_q - 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= WD_RELOAD;
    else        wd_q <= wd_d;
  end
`endif

  assign value   = value_q;
  assign clamped = clamped_q;
  assign settled = settled_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_udpoti_setpoint.sv
// Directed bench for udpoti_setpoint (RESOLUTION=100, SLEW_DIV=4, TIMEOUT=20).
module tb_udpoti_setpoint;

`ifdef UDPOTI_SETPOINT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] setpoint;
  logic        setpoint_valid;
  logic        enable;
  logic [31:0] value;
  logic        clamped, settled, fault;

  int passed = 0;
  int total  = 0;

  udpoti_setpoint #(.RESOLUTION(100), .SLEW_DIV(4), .TIMEOUT(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .setpoint       (setpoint),
    .setpoint_valid (setpoint_valid),
    .enable         (enable),
    .value          (value),
    .clamped        (clamped),
    .settled        (settled),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; setpoint_valid = 1'b0; setpoint = '0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_value",   value,   0);
      chk("rst_settled", settled, 1);
      chk("rst_fault",   fault,   0);
      chk("rst_clamped", clamped, 0);
    end
    rst_n = 1'b1;
    step(1);
    chk("post_rst_value",   value,   0);
    chk("post_rst_settled", settled, 1);

    // Ramp to 5; strobe held so the watchdog keeps reloading.
    enable = 1'b1; setpoint = 32'd5; setpoint_valid = 1'b1;
    step(1);
    chk("latch5_settled", settled, 0);
    chk("latch5_clamped", clamped, 0);
    chk("latch5_value",   value,   0);
    step(1);
    chk("pre_tick_value", value, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("ramp_step",    value,   k);
      chk("ramp_settled", settled, (k == 5) ? 1 : 0);
      step(3);
      chk("ramp_hold",    value,   k);
    end
    step(8);
    chk("no_overshoot", value,   5);
    chk("settled5",     settled, 1);

    // Clamp high.
    setpoint = 32'd250;
    step(1);
    chk("clamp_hi_flag",  clamped, 1);
    chk("clamp_hi_value", value,   5);
    step(400);
    chk("clamp_hi_final",   value,   100);
    chk("clamp_hi_settled", settled, 1);

    // Clamp low.
    setpoint = -32'sd7;
    step(1);
    chk("clamp_lo_flag", clamped, 1);
    step(420);
    chk("clamp_lo_final",   value,   0);
    chk("clamp_lo_settled", settled, 1);

    // In-range.
    setpoint = 32'd42;
    step(1);
    chk("inrange_flag", clamped, 0);
    step(200);
    chk("inrange_final", value, 42);
    setpoint = 32'd10;
    step(150);
    chk("at10", value, 10);

    // Drop enable: slew down to 0 at tick rate.
    setpoint_valid = 1'b0; enable = 1'b0;
    step(5);
    chk("down_first", value, 9);
    step(36);
    chk("down_zero",    value,   0);
    chk("down_settled", settled, 1);
    step(8);
    chk("down_hold", value, 0);

    // Watchdog: single strobe then silence.
    setpoint = 32'd3; setpoint_valid = 1'b1; enable = 1'b1;
    step(1);
    setpoint_valid = 1'b0;
    step(18);
    chk("wd_pre_fault", fault, 0);
    chk("wd_pre_value", value, 3);
    step(1);
    chk("wd_edge19_fault", fault, 0);
    step(1);
    chk("wd_fault", fault, WD ? 1 : 0);
    step(16);
    chk("wd_fault_value", value, WD ? 0 : 3);
    chk("wd_fault_hold",  fault, WD ? 1 : 0);
    enable = 1'b0;
    step(1);
    chk("wd_clear", fault, 0);
    step(16);
    chk("wd_idle_value", value, 0);

    // Strobe in the expiring cycle: reload wins.
    enable = 1'b1; setpoint = 32'd3; setpoint_valid = 1'b1;
    step(1);
    setpoint_valid = 1'b0;
    step(19);
    chk("wd2_pre", fault, 0);
    setpoint_valid = 1'b1;
    step(1);
    chk("wd2_reload_wins", fault, 0);
    setpoint_valid = 1'b0;
    step(19);
    chk("wd2_still_ok", fault, 0);
    chk("wd2_value",    value, 3);
    step(1);
    chk("wd2_fault", fault, WD ? 1 : 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/udpoti_setpoint.md
Name: udpoti_setpoint

Overview:
- Upstream conditioner for the up/down digital-potentiometer driver.
- Latches a signed 32-bit host setpoint on a strobe and clamps it to 0..RESOLUTION.
- Slews its `value` output toward the clamped target one step at a time, so the pot driver never sees a jump larger than one step per slew tick.
- A host-update watchdog forces the output back to 0 when host updates stop arriving.

Parameters:
- RESOLUTION, 100: number of pot steps; the highest legal `value`.
- SLEW_DIV, 200000: clk cycles per one-step change of `value`; must be ≥1.
- TIMEOUT, 50000000: clk cycles without a `setpoint_valid` before the watchdog faults; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- setpoint  in  32  signed host setpoint, in pot steps
- setpoint_valid  in  1  one-cycle strobe; latch `setpoint`
- enable  in  1  1 = track target; 0 = slew toward 0
- value  out  32  unsigned step position fed to the pot driver `value` input
- clamped  out  1  last latched setpoint was outside 0..RESOLUTION
- settled  out  1  `value` equals the effective target
- fault  out  1  watchdog expired (sticky until cleared)

Behaviour:
- Reset, applied when rst_n=0 at a clk edge:
  - value=0, clamped=0, settled=1, fault=0.
  - Target=0, slew counter=SLEW_DIV-1, watchdog counter=TIMEOUT-1, state=IDLE.
  - Reset mid-slew abandons the slew immediately. Output steps to 0 in one cycle; that jump is acceptable only under reset.
- Latch, on a clk edge with setpoint_valid=1:
  - Signed compare of `setpoint`.
  - setpoint<0: target=0, clamped=1.
  - setpoint>RESOLUTION: target=RESOLUTION, clamped=1.
  - Otherwise: target=setpoint, clamped=0.
  - The new target is used from the next cycle.
  - The strobe also reloads the watchdog counter.
- Effective target:
  - Equals target when state=TRACK.
  - Equals 0 when state is IDLE or FAULT.
- Slew tick:
  - The slew counter decrements every cycle.
  - At 0 it reloads to SLEW_DIV-1 and asserts an internal tick for one cycle.
  - On tick: if value<effective target, value+1; if value>effective target, value-1; otherwise no change.
  - Change rate is exactly one step per SLEW_DIV cycles.
  - `value` never wraps below 0 or above RESOLUTION.
- settled is registered: it equals (value==effective target) as evaluated after each update.
- State machine:
  - IDLE→TRACK: enable=1 and fault=0.
  - TRACK→IDLE: enable=0.
  - TRACK→FAULT: watchdog counter reaches 0 while in TRACK; fault=1 on the same edge.
  - FAULT→IDLE: enable=0 seen for one cycle; fault clears on that edge.
  - In FAULT, setpoint_valid still latches target but does not leave FAULT.
- Watchdog counting:
  - Decrements only in TRACK; saturates at 0.
  - Reloaded on any setpoint_valid or on entry to TRACK.
- Simultaneous events:
  - setpoint_valid in the same cycle the watchdog would hit 0: reload wins, no fault.
  - setpoint_valid with enable falling: target latched, state goes IDLE.
- Arithmetic:
  - 32-bit compares; setpoint is signed, value is unsigned.
  - RESOLUTION is treated as a non-negative 32-bit constant.

Optional Feature:
- Macro: UDPOTI_SETPOINT_WATCHDOG_EN.
- Defined: watchdog, FAULT state and `fault` output behave as specified above.
- Undefined:
  - Watchdog logic is removed and FAULT is unreachable.
  - `fault` is tied 0.
  - TIMEOUT is ignored.

Decomposition:
- Shared package udpoti_pkg holds:
  - the state enum (IDLE, TRACK, FAULT);
  - a 32-bit width localparam;
  - a clamp function (signed in, bounds, returns target and clamped flag).
- One sub-module: udpoti_tick_div, a reloadable down-counter producing the one-cycle tick.
  - Reused for the slew tick.
  - Also natural for the pot driver's own control clock later.

Test Plan:
- Reset, SLEW_DIV=4: hold rst_n=0 for 3 cycles, then release → value=0, settled=1, fault=0, clamped=0 throughout.
- enable=1, setpoint=5 strobed, SLEW_DIV=4 → value steps 1,2,3,4,5, one step every 4 cycles; settled=1 after reaching 5; no overshoot.
- Clamp with RESOLUTION=100:
  - setpoint=250 → target 100, clamped=1.
  - setpoint=-7 → target 0, clamped=1.
  - setpoint=42 → clamped=0.
- From value=10, drop enable → value ramps down to 0 at the slew rate; state is IDLE; settled=1 at 0.
- Watchdog with TIMEOUT=20 and the macro defined:
  - No strobe for 20 TRACK cycles → fault=1, value slews to 0.
  - enable low for one cycle → fault=0.
  - A strobe on cycle 20 → no fault.
- Build without UDPOTI_SETPOINT_WATCHDOG_EN: repeat the previous scenario → fault stays 0 and value holds its target.
